// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences one instruction over 3-5 clocks
// through a shared ALU/memory datapath, with memory-ready stalls, optional
// LUI/ORI support and a sticky illegal-instruction trap.
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 once memory is ready
// DECODE   | read registers, precompute branch target
// MEMADR   | compute load/store address rs + sign-ext imm
// MEMRD    | read data memory at ALUOut until ready
// MEMWB    | write loaded data into rt
// MEMWR    | write rt to data memory at ALUOut until ready
// EXECUTE  | R-type ALU operation on rs, rt
// ALUWB    | write ALU result into rd
// BRANCH   | BEQ compare, load PC with branch target when equal
// IMMEXEC  | ADDI / ORI / LUI ALU operation with extended immediate
// IMMWB    | write immediate result into rt
// JUMP     | load PC with jump target
// TRAP     | unsupported instruction, hold until reset
module mips_multicycle_ctrl #(
  parameter bit MEM_READY_EN = 1'b1,
  parameter bit IMM_LOGIC_EN = 1'b1,
  parameter int ALUCTRL_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 pcen,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [1:0]           immtype,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic [3:0]           state,
  output logic                 illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0111);

  state_t state_q, state_d;
  logic   rdy;
  logic   pcwrite, branch, irwrite_s, regwrite_s, memwrite_s;

  assign rdy   = MEM_READY_EN ? mem_ready : 1'b1;
  assign state = state_q;

  // State register; reset returns to FETCH without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state selection and Moore outputs; every output defaults to 0.
  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regwrite_s = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    immtype    = 2'b00;
    alucontrol = '0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite_s  = rdy;
        pcwrite    = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXECUTE;
          OP_BEQ:         state_d = S_BRANCH;
          OP_ADDI:        state_d = S_IMMEXEC;
          OP_LUI, OP_ORI: state_d = IMM_LOGIC_EN ? S_IMMEXEC : S_TRAP;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        state_d    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        state_d = S_ALUWB;
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: state_d    = S_TRAP;
        endcase
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_IMMEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_IMMWB;
        case (op)
          OP_ORI: begin
            immtype    = 2'b01;
            alucontrol = ALU_OR;
          end
          OP_LUI: begin
            immtype    = 2'b10;
            alucontrol = ALU_OR;
          end
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_IMMWB: begin
        regwrite_s = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are held off for the whole reset window, not just at the edge.
  assign irwrite  = reset_n & irwrite_s;
  assign pcen     = reset_n & (pcwrite | (branch & zero));
  assign regwrite = reset_n & regwrite_s;
  assign memwrite = reset_n & memwrite_s;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle successor to the single-cycle MIPS controller: a Moore FSM that sequences one instruction over 3-5 clocks through a shared ALU/memory datapath. It adds variable-latency memory (mem_ready stall), an optional immediate-logic group (LUI/ORI), and a sticky illegal-instruction trap. It drives the multicycle datapath's enables and muxes; op/funct come from the datapath's instruction register.

Parameters:
MEM_READY_EN, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored (treated as 1)
IMM_LOGIC_EN, 1, 1 = LUI (001111) and ORI (001101) supported; 0 = both trap as illegal
ALUCTRL_W, 4, alucontrol width; codes zero-extended: add 0010, sub 0110, and 0000, or 0001, slt 0111

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
op  in  6  opcode from instruction register
funct  in  6  function field from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completed access this cycle
iord  out  1  memory address: 0 = PC, 1 = ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
pcen  out  1  PC load = pcwrite | (branch & zero)
regwrite  out  1  register file write
regdst  out  1  write reg: 0 = rt, 1 = rd
memtoreg  out  1  writeback: 0 = ALUOut, 1 = mem data
alusrca  out  1  ALU A: 0 = PC, 1 = rs
alusrcb  out  2  ALU B: 00 rt, 01 const 4, 10 extended imm, 11 imm<<2
pcsrc  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target
immtype  out  2  00 sign-ext, 01 zero-ext, 10 upper (imm<<16)
alucontrol  out  ALUCTRL_W  ALU operation
state  out  4  current state (debug)
illegal  out  1  high in TRAP

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IMMEXEC 9, IMMWB 10, JUMP 11, TRAP 15. Register only state; all outputs combinational from state (+zero, mem_ready). Unlisted outputs are 0 in each state.
- reset_n low (async): state <= FETCH immediately. While low, force irwrite, pcen, regwrite, memwrite to 0. After release, first rising edge evaluates FETCH normally.
- "rdy" = mem_ready if MEM_READY_EN, else 1.
- FETCH: iord 0, alusrca 0, alusrcb 01, add, pcsrc 00, irwrite = pcen = rdy. Go to DECODE if rdy, else stay.
- DECODE: alusrca 0, alusrcb 11, add. Next by op: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> IMMEXEC; 001111/001101 -> IMMEXEC if IMM_LOGIC_EN, else TRAP; 000010 -> JUMP; other -> TRAP.
- MEMADR: alusrca 1, alusrcb 10, immtype 00, add. Go to MEMRD (LW) or MEMWR (SW).
- MEMRD: iord 1. Stay until rdy, then MEMWB.
- MEMWB: regdst 0, memtoreg 1, regwrite 1. Go to FETCH.
- MEMWR: iord 1, memwrite 1 every cycle in state (memory commits on rdy). Stay until rdy, then FETCH.
- EXECUTE: alusrca 1, alusrcb 00. alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Supported funct -> ALUWB. Other funct -> TRAP, regwrite never asserted.
- ALUWB: regdst 1, memtoreg 0, regwrite 1. Go to FETCH.
- BRANCH: alusrca 1, alusrcb 00, sub, pcsrc 01, pcen = zero. Go to FETCH.
- IMMEXEC: alusrca 1, alusrcb 10. ADDI: immtype 00, add. ORI: immtype 01, or. LUI: immtype 10, or. Go to IMMWB.
- IMMWB: regdst 0, memtoreg 0, regwrite 1. Go to FETCH.
- JUMP: pcsrc 10, pcen 1. Go to FETCH.
- TRAP: illegal 1, all enables 0. Stay until reset_n low.
- op/funct must be stable from DECODE until the next FETCH; FSM does not latch them.
- Cycle counts with zero wait: R/ADDI/LUI/ORI/SW 4, LW 5, BEQ/J 3. Each wait cycle in FETCH, MEMRD, or MEMWR adds 1.
- Illegal state codes (12-14): next state FETCH.

Test Plan:
- Reset mid-MEMWR (memwrite 1), drop reset_n between edges -> state 0 and memwrite 0 with no clock edge; irwrite 0 until release.
- op 000000, funct 100000, mem_ready 1 -> states 0,1,6,7,0; alucontrol 0010 in EXECUTE; regwrite and regdst 1 only in ALUWB.
- LW (100011), mem_ready low 2 cycles in FETCH and 3 in MEMRD -> 10 cycles total; irwrite/pcen pulse exactly once; memtoreg and regwrite 1 in MEMWB.
- BEQ (000100) with zero=1, then with zero=0 -> pcen 1, then 0, in BRANCH; pcsrc 01, alucontrol 0110; 3 cycles each.
- LUI (001111) -> IMMEXEC immtype 10, alucontrol 0001, IMMWB regwrite 1. With IMM_LOGIC_EN=0 -> state 15, illegal 1, held for 20 cycles until reset.
- op 000000, funct 000011 -> TRAP from EXECUTE, regwrite never 1. op 000010 -> JUMP with pcsrc 10 and pcen 1, then FETCH.
